// File: rtl/alu32_arbiter.sv
// Two-requester round-robin arbiter sharing one 32-bit add/sub unit,
// with a single registered response slot and per-requester completion counters.
//
// state | meaning
// EMPTY | response slot holds nothing, rsp_valid=0
// FULL  | response slot holds a result, rsp_valid=1
module alu32_arbiter #(
    parameter int PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_sub,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_sub,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    // last_q holds the most recent winner; resetting it to the other side
    // makes PRIO_INIT win the first contended cycle.
    localparam logic LAST_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    logic        slot_free;
    logic        drain;
    logic        grant0, grant1;
    logic        accept;
    logic        op_sub;
    logic [31:0] op_a, op_b, b_eff;
    logic [32:0] sum33;

    always_comb begin
        drain     = (state_q == FULL) && rsp_ready;
        slot_free = (state_q == EMPTY) || drain;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (!rst && slot_free) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_q;
                grant1 = !last_q;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
        accept = grant0 || grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Subtract is a + ~b + 1; the +1 rides in as the carry-in.
    always_comb begin
        op_a   = grant1 ? req1_a   : req0_a;
        op_b   = grant1 ? req1_b   : req0_b;
        op_sub = grant1 ? req1_sub : req0_sub;
        b_eff  = op_sub ? ~op_b : op_b;
        sum33  = {1'b0, op_a} + {1'b0, b_eff} + {32'd0, op_sub};
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;

        if (drain) begin
            if (!id_q && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
            if (id_q && cnt1_q != 16'hFFFF)  cnt1_d = cnt1_q + 16'd1;
        end

        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (drain && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        if (accept) begin
            last_d   = grant1;
            id_d     = grant1;
            result_d = sum33[31:0];
            carry_d  = sum33[32];
            zero_d   = (sum33[31:0] == 32'd0);
            ovf_d    = (op_a[31] == b_eff[31]) && (sum33[31] != op_a[31]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            last_q   <= LAST_INIT;
            id_q     <= 1'b0;
            result_q <= 32'd0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt0_q   <= 16'd0;
            cnt1_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign rsp_valid    = (state_q == FULL);
    assign rsp_id       = id_q;
    assign rsp_result   = result_q;
    assign rsp_carry    = carry_q;
    assign rsp_zero     = zero_q;
    assign rsp_overflow = ovf_q;
    assign cnt0         = cnt0_q;
    assign cnt1         = cnt1_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter: reset, ALU flags, round-robin order,
// backpressure hold, and reset while a result is pending.
module tb_alu32_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_carry, rsp_zero, rsp_overflow;
    logic [15:0] cnt0, cnt1;

    int n_checks = 0;
    int n_errors = 0;

    alu32_arbiter #(.PRIO_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [31:0] res,
                           input logic c, input logic z, input logic v);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_result"}, rsp_result, res);
        chk({tag, "_carry"}, 32'(rsp_carry), 32'(c));
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(z));
        chk({tag, "_ovf"}, 32'(rsp_overflow), 32'(v));
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b1; req1_sub = 1'b0; req1_a = 32'd0; req1_b = 32'd0;

        // Reset held two cycles with requests pending
        tick(); tick();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        // Signed overflow on add
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 32'h7FFF_FFFF; req0_b = 32'h1;
        #1;
        chk("ovf_rdy0", 32'(req0_ready), 32'd1);
        chk("ovf_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk_rsp("ovf", 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ovf_drain_valid", 32'(rsp_valid), 32'd0);
        chk("ovf_cnt0", 32'(cnt0), 32'd1);

        // Subtract to zero, then borrow case accepted on the drain cycle
        req1_valid = 1'b1; req1_sub = 1'b1; req1_a = 32'd5; req1_b = 32'd5;
        #1;
        chk("sub0_rdy1", 32'(req1_ready), 32'd1);
        tick();
        chk_rsp("sub0", 1'b1, 32'd0, 1'b1, 1'b1, 1'b0);
        req1_a = 32'd0; req1_b = 32'd1; rsp_ready = 1'b1;
        #1;
        chk("sub1_rdy1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk_rsp("sub1", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        chk("sub1_cnt1", 32'(cnt1), 32'd1);
        tick();
        rsp_ready = 1'b0;
        chk("sub1_drain_valid", 32'(rsp_valid), 32'd0);
        chk("sub1_cnt1b", 32'(cnt1), 32'd2);

        // Round-robin from fresh reset, both requesters always valid
        rst = 1'b1; tick(); rst = 1'b0;
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 32'd3; req0_b = 32'd4;
        req1_valid = 1'b1; req1_sub = 1'b1; req1_a = 32'd3; req1_b = 32'd4;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_rdy1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr_id", 32'(rsp_id), 32'(i % 2));
            chk("rr_result", rsp_result, (i % 2 == 0) ? 32'd7 : 32'hFFFF_FFFF);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("rr_valid_end", 32'(rsp_valid), 32'd0);
        chk("rr_cnt0", 32'(cnt0), 32'd2);
        chk("rr_cnt1", 32'(cnt1), 32'd2);

        // Backpressure: slot held for three cycles, then drain plus accept
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
        tick();
        req1_valid = 1'b1; req1_sub = 1'b0; req1_a = 32'd2; req1_b = 32'd3;
        req0_a = 32'd9; req0_b = 32'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy0", 32'(req0_ready), 32'd0);
            chk("bp_rdy1", 32'(req1_ready), 32'd0);
            tick();
            chk_rsp("bp_hold", 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_rdy0", 32'(req0_ready), 32'd0);
        chk("bp_rel_rdy1", 32'(req1_ready), 32'd1);
        tick();
        chk_rsp("bp_new", 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
        chk("bp_cnt0", 32'(cnt0), 32'd3);

        // Leave req0 as last winner, then reset while FULL with rsp_ready=1
        req1_valid = 1'b0;
        req0_a = 32'd1; req0_b = 32'd1;
        tick();
        req0_valid = 1'b0;
        chk("pre_rst_id", 32'(rsp_id), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cnt0", 32'(cnt0), 32'd0);
        chk("mid_rst_cnt1", 32'(cnt1), 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_rst_rdy0", 32'(req0_ready), 32'd1);
        chk("mid_rst_rdy1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu32_arbiter.md
ALU32_ARBITER -- requirements
Module: alu32_arbiter

Interface
REQ-001 SHALL have parameter PRIO_INIT, default 0, meaning the requester (0 or 1) that wins the first contended cycle after reset.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 SHALL have ports reqN_ready  output  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports reqN_sub  input  1  0 = add, 1 = subtract (a - b).
REQ-007 SHALL have ports reqN_a, reqN_b  input  32  two's-complement operands.
REQ-008 SHALL have port rsp_valid  output  1  response register holds a result.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes the response this cycle.
REQ-010 SHALL have port rsp_id  output  1  requester that issued the held result.
REQ-011 SHALL have port rsp_result  output  32  a+b or a-b, modulo 2^32.
REQ-012 SHALL have ports rsp_carry, rsp_zero, rsp_overflow  output  1 each  ALU flags of the held result.
REQ-013 SHALL have ports cnt0, cnt1  output  16  completed-response count per requester.

Function
REQ-014 SHALL share one 32-bit add/sub datapath between the two requesters; one operation accepted per cycle at most.
REQ-015 SHALL implement a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 SHALL treat the slot as free when state is EMPTY, or FULL with rsp_valid && rsp_ready in the same cycle.
REQ-017 SHALL assert at most one reqN_ready per cycle, only when the slot is free and reqN_valid=1; reqN_ready SHALL NOT depend combinationally on reqN_a/b/sub.
REQ-018 SHALL grant the sole valid requester when only one is valid.
REQ-019 SHALL, when both valid, grant the requester not granted most recently (round-robin); the last-grant pointer updates only on acceptance.
REQ-020 SHALL register result, flags and rsp_id on acceptance; rsp_valid SHALL rise on the cycle after acceptance (latency 1).
REQ-021 SHALL, on drain without a new acceptance, go FULL->EMPTY; on drain with acceptance, stay FULL with the new result loaded (back-to-back throughput 1/cycle).
REQ-022 SHALL hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-023 SHALL compute subtract as a + ~b + 1 in 33 bits.
REQ-024 SHALL set carry = bit 32 of the 33-bit sum (for subtract: 1 = no borrow, 0 = borrow).
REQ-025 SHALL set overflow = 1 when operand-effective signs match and result sign differs (signed overflow), else 0.
REQ-026 SHALL set zero = 1 exactly when the 32-bit result is 0.
REQ-027 SHALL increment cntN on each rsp handshake with rsp_id=N, saturating at 0xFFFF (no wrap).
REQ-028 SHALL ignore rsp_ready while EMPTY.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force state EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, all flags 0, cnt0=cnt1=0, last-grant pointer such that PRIO_INIT wins next contention.
REQ-030 SHALL hold both reqN_ready=0 while rst=1.
REQ-031 SHALL discard a FULL result when reset mid-operation; no handshake or count increment occurs on that cycle.

Verification
REQ-032 Reset: rst=1 two cycles -> rsp_valid=0, cnt0=cnt1=0, req0_ready=req1_ready=0.
REQ-033 req0 add a=0x7FFFFFFF b=0x00000001 -> next cycle rsp_valid=1, rsp_id=0, result=0x80000000, overflow=1, carry=0, zero=0.
REQ-034 req1 sub a=5 b=5 -> result=0, zero=1, carry=1, overflow=0; then req1 sub a=0 b=1 -> result=0xFFFFFFFF, carry=0, overflow=0.
REQ-035 Both valid every cycle, rsp_ready=1, PRIO_INIT=0 -> rsp_id sequence 0,1,0,1; cnt0=cnt1=2 after four responses.
REQ-036 Backpressure: rsp_ready=0 for 3 cycles while FULL -> rsp_* constant, both reqN_ready=0; rsp_ready=1 -> drain and new acceptance same cycle.
REQ-037 Reset while FULL with rsp_ready=1 -> rsp_valid=0 next cycle, counts 0, next contention won by PRIO_INIT.
